div_issue_ctrl: RTL and testbench

- Issue and collect controller between the EXE-stage pipeline and the 32-cycle iterative divider.
- Accepts a divide request over valid/ready, latches operands and holds them stable for the divider.
- Runs the divider and captures quotient/remainder on done, then holds the result on a valid/ready output toward HI/LO or writeback.
- Handles divide-by-zero locally and aborts cleanly on pipeline flush (cancel).

---
 rtl/div_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/collect controller between the EXE stage and the
// 32-cycle iterative divider. Holds operands stable for the divider, captures
// its result, resolves divide-by-zero locally and aborts cleanly on flush.
module div_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_q,
  output logic [31:0]      res_r,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dbz,
  output logic             dv_rst,
  output logic             dv_div,
  output logic             dv_signed,
  output logic [31:0]      dv_x,
  output logic [31:0]      dv_y,
  input  logic [31:0]      dv_s,
  input  logic [31:0]      dv_r,
  input  logic             dv_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               dbz_s;
  logic               capture_s;
  logic [31:0]        op_x_r;
  logic [31:0]        op_y_r;
  logic               op_signed_r;
  logic [TAG_W-1:0]   op_tag_r;

  // A new request may land in IDLE, or in HOLD on the same edge the held
  // result is consumed; a flush blocks acceptance altogether.
  assign req_ready = ~cancel & ((state_r == IDLE) | ((state_r == HOLD) & res_ready));
  assign accept_s  = req_valid & req_ready;
  assign dbz_s     = (req_y == 32'd0);

  // Cancel wins over a coincident dv_done, so the result is only taken when
  // the op is still live.
  assign capture_s = (state_r == RUN) & dv_done & ~cancel;

  // The divider is cleared only through its reset; a flush during RUN is the
  // sole mid-operation path.
  assign dv_rst    = rst | (cancel & (state_r == RUN));
  assign dv_div    = (state_r == RUN) & ~cancel;

  // Operand registers feed the divider directly so the inputs stay constant
  // until completion, when the divider re-reads the signs.
  assign dv_x      = op_x_r;
  assign dv_y      = op_y_r;
  assign dv_signed = op_signed_r;

  assign res_valid = (state_r == HOLD);

  // State register.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection; a zero divisor bypasses the divider entirely.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = dbz_s ? HOLD : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          state_nxt_s = IDLE;
        end else if (dv_done) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HOLD: begin
        if (cancel) begin
          state_nxt_s = IDLE;
        end else if (res_ready) begin
          if (accept_s) begin
            state_nxt_s = dbz_s ? HOLD : RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture on every accepted request.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      op_x_r      <= 32'd0;
      op_y_r      <= 32'd0;
      op_signed_r <= 1'b0;
      op_tag_r    <= '0;
    end else if (accept_s) begin
      op_x_r      <= req_x;
      op_y_r      <= req_y;
      op_signed_r <= req_signed;
      op_tag_r    <= req_tag;
    end else begin
      op_x_r      <= op_x_r;
      op_y_r      <= op_y_r;
      op_signed_r <= op_signed_r;
      op_tag_r    <= op_tag_r;
    end
  end

  // Result registers: loaded directly for divide-by-zero, otherwise from the
  // divider when it finishes.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      res_q   <= 32'd0;
      res_r   <= 32'd0;
      res_tag <= '0;
      res_dbz <= 1'b0;
    end else if (accept_s) begin
      if (dbz_s) begin
        res_q   <= 32'hFFFF_FFFF;
        res_r   <= req_x;
        res_tag <= req_tag;
        res_dbz <= 1'b1;
      end else begin
        res_dbz <= 1'b0;
      end
    end else if (capture_s) begin
      res_q   <= dv_s;
      res_r   <= dv_r;
      res_tag <= op_tag_r;
    end else begin
      res_q   <= res_q;
      res_r   <= res_r;
      res_tag <= res_tag;
      res_dbz <= res_dbz;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: emulates the 32-cycle divider, keeps a
// latency-based reference model checked every cycle, and runs directed
// vectors with hand-computed expectations.
module tb_div_issue_ctrl;
  localparam int TAG_W = 5;

  logic             div_clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [31:0]      req_x;
  logic [31:0]      req_y;
  logic [TAG_W-1:0] req_tag;
  logic             cancel;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_q;
  logic [31:0]      res_r;
  logic [TAG_W-1:0] res_tag;
  logic             res_dbz;
  logic             dv_rst;
  logic             dv_div;
  logic             dv_signed;
  logic [31:0]      dv_x;
  logic [31:0]      dv_y;
  logic [31:0]      dv_s;
  logic [31:0]      dv_r;
  logic             dv_done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic spur = 1'b0;
  logic div_seen = 1'b0;
  int n;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .div_clk(div_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .cancel(cancel),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_r(res_r),
    .res_tag(res_tag), .res_dbz(res_dbz),
    .dv_rst(dv_rst), .dv_div(dv_div), .dv_signed(dv_signed), .dv_x(dv_x),
    .dv_y(dv_y), .dv_s(dv_s), .dv_r(dv_r), .dv_done(dv_done)
  );

  // Clock.
  always #5 div_clk = ~div_clk;

  // Reference division: truncating quotient, remainder takes dividend sign,
  // signed overflow passes through as q=0x80000000, r=0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] xs, ys, sq, sr;
    if (!sgn) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0000_0000};
    xs = x; ys = y;
    sq = xs / ys; sr = xs % ys;
    return {sq, sr};
  endfunction

  // Divider emulation: counts edges with dv_div, done in the 33rd run cycle.
  int unsigned dcount = 0;
  always @(posedge div_clk) begin
    if (dv_rst) dcount <= 0;
    else if (dv_div) dcount <= (dcount == 32) ? 0 : dcount + 1;
  end
  assign dv_done = (dcount == 32) | spur;

  // Divider result bus: real value only while done, junk otherwise.
  always_comb begin
    {dv_s, dv_r} = {32'hDEAD_BEEF, 32'h0BAD_F00D};
    if (dcount == 32 && dv_y != 32'd0) {dv_s, dv_r} = ref_div(dv_signed, dv_x, dv_y);
  end

  // Reference model: remaining-latency counter plus a held result slot.
  int               m_left = 0, n_left;
  bit               m_has = 1'b0, n_has;
  logic [31:0]      m_q = 32'd0, m_r = 32'd0, m_pq = 32'd0, m_pr = 32'd0;
  logic [31:0]      n_q, n_r, n_pq, n_pr;
  logic [31:0]      m_ox = 32'd0, m_oy = 32'd0, n_ox, n_oy;
  logic             m_os = 1'b0, m_dbz = 1'b0, n_os, n_dbz;
  logic [TAG_W-1:0] m_tag = '0, m_ptag = '0, n_tag, n_ptag;
  logic             exp_ready, acc;

  assign exp_ready = !cancel && ((m_left == 0 && !m_has) || (m_has && res_ready));
  assign acc = req_valid && exp_ready;

  // Model next state from the rules: 33 cycles to a result, flush drops work.
  always_comb begin
    n_left = m_left; n_has = m_has; n_q = m_q; n_r = m_r; n_pq = m_pq; n_pr = m_pr;
    n_ox = m_ox; n_oy = m_oy; n_os = m_os; n_dbz = m_dbz; n_tag = m_tag; n_ptag = m_ptag;
    if (rst) begin
      n_left = 0; n_has = 1'b0; n_q = 32'd0; n_r = 32'd0; n_dbz = 1'b0; n_tag = '0;
      n_ox = 32'd0; n_oy = 32'd0; n_os = 1'b0;
    end else begin
      if (m_left > 0) begin
        if (cancel) n_left = 0;
        else begin
          n_left = m_left - 1;
          if (m_left == 1) begin
            n_has = 1'b1; n_q = m_pq; n_r = m_pr; n_tag = m_ptag;
          end
        end
      end else if (m_has && (cancel || res_ready)) begin
        n_has = 1'b0;
      end
      if (acc) begin
        n_ox = req_x; n_oy = req_y; n_os = req_signed;
        if (req_y == 32'd0) begin
          n_has = 1'b1; n_q = 32'hFFFF_FFFF; n_r = req_x; n_dbz = 1'b1; n_tag = req_tag;
        end else begin
          n_left = 33; {n_pq, n_pr} = ref_div(req_signed, req_x, req_y);
          n_ptag = req_tag; n_dbz = 1'b0;
        end
      end
    end
  end

  // Model state register.
  always @(posedge div_clk) begin
    m_left <= n_left; m_has <= n_has; m_q <= n_q; m_r <= n_r; m_pq <= n_pq; m_pr <= n_pr;
    m_ox <= n_ox; m_oy <= n_oy; m_os <= n_os; m_dbz <= n_dbz; m_tag <= n_tag; m_ptag <= n_ptag;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge div_clk) begin
    if (chk_en) begin
      chk("m_res_valid", res_valid, m_has);
      chk("m_req_ready", req_ready, exp_ready);
      chk("m_dv_div", dv_div, (m_left > 0) && !cancel);
      chk("m_dv_rst", dv_rst, rst || (m_left > 0 && cancel));
      chk("m_dv_x", dv_x, m_ox);
      chk("m_dv_y", dv_y, m_oy);
      chk("m_dv_signed", dv_signed, m_os);
      if (m_has) begin
        chk("m_res_q", res_q, m_q);
        chk("m_res_r", res_r, m_r);
        chk("m_res_tag", res_tag, m_tag);
        chk("m_res_dbz", res_dbz, m_dbz);
      end
    end
  end

  // Records any divider start, used by the divide-by-zero vector.
  always @(negedge div_clk) begin
    if (dv_div) div_seen <= 1'b1;
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge div_clk);
      #1;
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_signed = s; req_x = x; req_y = y; req_tag = t;
    cyc(1);
    req_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until res_valid, bounded.
  task automatic wait_res(output int cnt);
    cnt = 0;
    while (!res_valid && cnt < 100) begin
      cyc(1);
      cnt++;
    end
  endtask

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed vectors.
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_x = 32'd0; req_y = 32'd0;
    req_tag = '0; cancel = 1'b0; res_ready = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_q", res_q, 32'd0);
    chk("rst_r", res_r, 32'd0);
    chk("rst_tag", res_tag, 5'd0);
    chk("rst_dbz", res_dbz, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk_en = 1'b1;

    // unsigned 100/7
    issue(1'b0, 32'd100, 32'd7, 5'd3);
    wait_res(n);
    chk("u_lat", n, 33);
    chk("u_q", res_q, 32'd14);
    chk("u_r", res_r, 32'd2);
    chk("u_dbz", res_dbz, 1'b0);
    chk("u_tag", res_tag, 5'd3);
    cyc(1);
    chk("u_drain", res_valid, 1'b0);

    // signed -7/2
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4);
    wait_res(n);
    chk("s_q", res_q, 32'hFFFF_FFFD);
    chk("s_r", res_r, 32'hFFFF_FFFF);
    cyc(1);

    // signed overflow passes through
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    wait_res(n);
    chk("ov_q", res_q, 32'h8000_0000);
    chk("ov_r", res_r, 32'd0);
    cyc(1);

    // divide by zero
    div_seen = 1'b0;
    issue(1'b0, 32'd5, 32'd0, 5'd6);
    chk("dbz_next_cycle", res_valid, 1'b1);
    chk("dbz_q", res_q, 32'hFFFF_FFFF);
    chk("dbz_r", res_r, 32'd5);
    chk("dbz_flag", res_dbz, 1'b1);
    chk("dbz_tag", res_tag, 5'd6);
    cyc(1);
    chk("dbz_no_div", div_seen, 1'b0);

    // cancel in run cycle 10, then 20/3 proves divider was cleared
    issue(1'b0, 32'd1000, 32'd3, 5'd7);
    cyc(9);
    cancel = 1'b1;
    #1;
    chk("cx_dv_rst", dv_rst, 1'b1);
    cyc(1);
    cancel = 1'b0;
    #1;
    chk("cx_dv_rst_off", dv_rst, 1'b0);
    chk("cx_no_valid", res_valid, 1'b0);
    cyc(2);
    issue(1'b0, 32'd20, 32'd3, 5'd8);
    wait_res(n);
    chk("cx_lat", n, 33);
    chk("cx_q", res_q, 32'd6);
    chk("cx_r", res_r, 32'd2);
    cyc(1);

    // backpressure, spurious done in HOLD, then same-edge handoff
    res_ready = 1'b0;
    issue(1'b0, 32'd50, 32'd8, 5'd9);
    wait_res(n);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_q", res_q, 32'd6);
      chk("bp_r", res_r, 32'd2);
      chk("bp_tag", res_tag, 5'd9);
    end
    spur = 1'b1;
    cyc(1);
    spur = 1'b0;
    chk("spur_hold_q", res_q, 32'd6);
    res_ready = 1'b1;
    req_valid = 1'b1; req_signed = 1'b0; req_x = 32'd9; req_y = 32'd4; req_tag = 5'd10;
    #1;
    chk("ho_ready", req_ready, 1'b1);
    cyc(1);
    req_valid = 1'b0;
    chk("ho_running", dv_div, 1'b1);
    wait_res(n);
    chk("ho_lat", n, 33);
    chk("ho_q", res_q, 32'd2);
    chk("ho_r", res_r, 32'd1);
    chk("ho_tag", res_tag, 5'd10);
    cyc(1);

    // spurious done in IDLE
    spur = 1'b1;
    cyc(1);
    spur = 1'b0;
    chk("spur_idle", res_valid, 1'b0);

    // cancel coincident with dv_done
    issue(1'b0, 32'd77, 32'd5, 5'd11);
    cyc(32);
    chk("cd_done", dv_done, 1'b1);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    chk("cd_dropped", res_valid, 1'b0);
    cyc(2);
    chk("cd_still_idle", res_valid, 1'b0);

    // cancel in HOLD
    res_ready = 1'b0;
    issue(1'b0, 32'd5, 32'd0, 5'd12);
    chk("ch_valid", res_valid, 1'b1);
    cancel = 1'b1;
    #1;
    chk("ch_ready", req_ready, 1'b0);
    cyc(1);
    cancel = 1'b0;
    chk("ch_dropped", res_valid, 1'b0);
    res_ready = 1'b1;

    // reset mid-run, then a signed op from a clean divider
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd13);
    cyc(5);
    rst = 1'b1;
    #1;
    chk("rr_dv_rst", dv_rst, 1'b1);
    cyc(1);
    rst = 1'b0;
    chk("rr_valid", res_valid, 1'b0);
    chk("rr_q", res_q, 32'd0);
    chk("rr_r", res_r, 32'd0);
    chk("rr_tag", res_tag, 5'd0);
    chk("rr_dbz", res_dbz, 1'b0);
    chk("rr_dv_x", dv_x, 32'd0);
    chk("rr_dv_div", dv_div, 1'b0);
    chk("rr_ready", req_ready, 1'b1);
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd14);
    wait_res(n);
    chk("rr_lat", n, 33);
    chk("rr2_q", res_q, 32'hFFFF_FFF2);
    chk("rr2_r", res_r, 32'hFFFF_FFFE);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
